step_to_freq: RTL and testbench



---
 rtl/step_to_freq.sv | 112 +++++++++++
 tb/tb_step_to_freq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/step_to_freq.sv
// Converts a DDS phase step into its output frequency in Hz:
// freq = round(step_val * CLK_HZ / 2^STEP_W), computed by a serial shift-add multiply.
module step_to_freq #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned STEP_W = 32,
    parameter int unsigned FREQ_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STEP_W-1:0] step_val,
    output logic              out_valid,
    output logic [FREQ_W-1:0] freq,
    output logic              sat
);
    localparam int unsigned ACC_W = STEP_W + 32;
    localparam int unsigned CNT_W = $clog2(STEP_W + 1);
    localparam logic [ACC_W-1:0]  CLK_EXT = ACC_W'(CLK_HZ);
    localparam logic [ACC_W:0]    HALF    = (ACC_W+1)'(1) << (STEP_W - 1);
    localparam logic [FREQ_W-1:0] F_MAX   = {FREQ_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(STEP_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, ROUND} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [STEP_W-1:0]   mult_q, mult_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic                sat_q, sat_d;
    logic                ovld_q, ovld_d;
    logic [ACC_W:0]      rnd;
    logic                over;

    // Round-half-up, then drop the STEP_W fractional bits; the extra MSB keeps the carry.
    assign rnd  = ({1'b0, acc_q} + HALF) >> STEP_W;
    assign over = |rnd[ACC_W:FREQ_W];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     if (cnt_q == CNT_END) state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    always_comb begin
        acc_d  = acc_q;
        mult_d = mult_q;
        cnt_d  = cnt_q;
        freq_d = freq_q;
        sat_d  = sat_q;
        ovld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mult_d = step_val;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            MUL: begin
                if (mult_q[0]) acc_d = acc_q + (CLK_EXT << cnt_q);
                mult_d = mult_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            ROUND: begin
                freq_d = over ? F_MAX : rnd[FREQ_W-1:0];
                sat_d  = over;
                ovld_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            mult_q <= '0;
            cnt_q  <= '0;
            freq_q <= '0;
            sat_q  <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mult_q <= mult_d;
            cnt_q  <= cnt_d;
            freq_q <= freq_d;
            sat_q  <= sat_d;
            ovld_q <= ovld_d;
        end
    end

    assign out_valid = ovld_q;
    assign freq      = freq_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_step_to_freq.sv
// Directed bench for step_to_freq: hand-computed frequencies, latency, handshake and reset cases.
module tb_step_to_freq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] step_val;
    logic        out_valid;
    logic [19:0] freq;
    logic        sat;

    int tests = 0;
    int fails = 0;

    step_to_freq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .step_val(step_val), .out_valid(out_valid), .freq(freq), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to 40 edges for out_valid; returns 0 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] s,
                           input int ef, input logic es);
        int lat;
        in_valid = 1'b1;
        step_val = s;
        tick();
        in_valid = 1'b0;
        step_val = 32'hDEAD_BEEF;
        wait_result(lat);
        check({tag, " latency"}, lat, 33);
        check({tag, " freq"}, freq, ef);
        check({tag, " sat"}, sat, es);
        tick();
        check({tag, " strobe width"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        int gap;
        logic seen;
        rst = 1'b1;
        in_valid = 1'b0;
        step_val = '0;
        tick();
        tick();
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset freq", freq, 0);
        check("reset sat", sat, 0);
        rst = 1'b0;
        tick();
        check("idle no accept", in_ready, 1);

        convert("zero", 32'd0, 0, 1'b0);
        convert("1kHz", 32'd85899, 1000, 1'b0);
        convert("round up", 32'd85, 1, 1'b0);
        convert("max unsat", 32'd90071906, 1048575, 1'b0);
        convert("just sat", 32'd90071993, 1048575, 1'b1);
        convert("full scale", 32'hFFFF_FFFF, 1048575, 1'b1);

        // Input activity during MUL must be ignored
        in_valid = 1'b1;
        step_val = 32'd858993;
        tick();
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            in_valid = k[0];
            step_val = 32'd85 + k;
            if (in_ready) seen = 1'b1;
            tick();
        end
        check("mul in_ready low", seen, 0);
        in_valid = 1'b0;
        wait_result(lat);
        check("ignore latency", lat, 3);
        check("ignore freq", freq, 10000);
        tick();
        tick();
        check("ignore no extra", out_valid, 0);

        // Back-to-back: second accept lands in the first out_valid cycle
        in_valid = 1'b1;
        step_val = 32'd85899;
        tick();
        step_val = 32'd858993;
        wait_result(lat);
        check("b2b first latency", lat, 33);
        check("b2b first freq", freq, 1000);
        check("b2b ready in strobe", in_ready, 1);
        tick();
        in_valid = 1'b0;
        step_val = 32'd0;
        check("b2b second accepted", in_ready, 0);
        wait_result(gap);
        check("b2b spacing", gap + 1, 34);
        check("b2b second freq", freq, 10000);

        // Reset in the middle of MUL discards the conversion
        tick();
        in_valid = 1'b1;
        step_val = 32'd85899;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst freq", freq, 0);
        check("midrst in_ready", in_ready, 1);
        wait_result(lat);
        check("midrst no result", lat, 0);
        convert("after reset", 32'd85899, 1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
